// File: rtl/edge_generator.sv
// edge_generator: turns single-cycle rise/fall requests into a clean output
// level that holds each value for at least HOLD_COUNT cycles. One opposite
// request can wait in a pending slot while a hold window runs.
module edge_generator #(
    parameter int unsigned HOLD_COUNT  = 32,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rise,
    input  logic fall,
    output logic signal,
    output logic busy,
    output logic dropped
);

    localparam int unsigned CNT_W = (HOLD_COUNT > 1) ? $clog2(HOLD_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             signal_q, signal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_level_q, pend_level_d;
    logic             dropped_q, dropped_d;

    // Pending slot after this cycle's request, before expiry is applied
    logic             pend_v_n;
    logic             pend_l_n;
    logic             req;
    logic             conflict;

    // Request decode: exactly one of rise/fall is a request, both is a conflict
    always_comb begin
        req      = rise ^ fall;
        conflict = rise & fall;
    end

    // State, level, counter, pending slot and dropped-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            signal_q     <= RESET_LEVEL;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_level_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            signal_q     <= signal_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_level_q <= pend_level_d;
            dropped_q    <= dropped_d;
        end
    end

    // Next-state: request handling, pending slot update, window expiry
    always_comb begin
        state_d      = state_q;
        signal_d     = signal_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_level_d = pend_level_q;
        dropped_d    = 1'b0;
        pend_v_n     = pend_valid_q;
        pend_l_n     = pend_level_q;

        if (conflict) begin
            dropped_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req && (rise != signal_q)) begin
                    signal_d = rise;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // Request is judged against the slot as it stands pre-expiry
                if (req) begin
                    if (rise != signal_q) begin
                        if (pend_valid_q) begin
                            dropped_d = 1'b1;
                        end
                        pend_v_n = 1'b1;
                        pend_l_n = rise;
                    end else if (pend_valid_q) begin
                        pend_v_n  = 1'b0;
                        dropped_d = 1'b1;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    // An empty slot filled this cycle behaves as an idle request
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    if (pend_v_n) begin
                        signal_d = pend_l_n;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    pend_valid_d = pend_v_n;
                    pend_level_d = pend_l_n;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign signal  = signal_q;
    assign busy    = (state_q == HOLD);
    assign dropped = dropped_q;

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: directed scenarios plus random requests, checked
// against a time-based reference model (last-toggle time and a pending level).
module tb_edge_generator;

    localparam int unsigned HOLD = 4;
    localparam logic        RST_LVL = 1'b0;

    logic clk;
    logic reset;
    logic rise;
    logic fall;
    logic sig;
    logic busy;
    logic dropped;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   cyc     = 0;
    int   t_last  = -1000;
    int   m_pend  = -1;
    logic m_sig   = RST_LVL;
    logic m_drop  = 1'b0;

    edge_generator #(
        .HOLD_COUNT  (HOLD),
        .RESET_LEVEL (RST_LVL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rise    (rise),
        .fall    (fall),
        .signal  (sig),
        .busy    (busy),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Model of one clock edge n: level changes at most once, and only when
    // the previous change is at least HOLD edges in the past.
    task automatic model_edge(input logic r, input logic f, input logic rs, input int n);
        int   age;
        bit   in_hold;
        logic tgt;
        m_drop = 1'b0;
        if (rs) begin
            m_sig  = RST_LVL;
            m_pend = -1;
            t_last = -1000;
            return;
        end
        age     = n - t_last;
        in_hold = (age <= int'(HOLD));
        tgt     = r;
        if (r && f) begin
            m_drop = 1'b1;
        end else if (r || f) begin
            if (in_hold) begin
                if (tgt != m_sig) begin
                    if (m_pend >= 0) m_drop = 1'b1;
                    m_pend = int'(tgt);
                end else if (m_pend >= 0) begin
                    m_pend = -1;
                    m_drop = 1'b1;
                end
            end else if (tgt != m_sig) begin
                m_sig  = tgt;
                t_last = n;
            end
        end
        if (in_hold && age == int'(HOLD)) begin
            if (m_pend >= 0) begin
                m_sig  = m_pend[0];
                t_last = n;
            end
            m_pend = -1;
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge
    task automatic step(input logic r, input logic f, input logic rs);
        logic m_busy;
        rise  = r;
        fall  = f;
        reset = rs;
        @(posedge clk);
        model_edge(r, f, rs, cyc);
        m_busy = ((cyc - t_last) < int'(HOLD));
        @(negedge clk);
        chk("signal", sig, m_sig);
        chk("busy", busy, m_busy);
        chk("dropped", dropped, m_drop);
        cyc++;
    endtask

    // Directed scenario: inputs keyed on step index k, after two reset cycles
    task automatic scn(input int id, input int r0, input int r1,
                       input int f0, input int f1, input int rs_at);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_signal", sig, RST_LVL);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", dropped, 1'b0);
        for (int k = 0; k < 24; k++) begin
            step(logic'(k == r0 || k == r1), logic'(k == f0 || k == f1), logic'(k == rs_at));
            if (id == 1 && k == 10) chk("s1_sig_hi", sig, 1'b1);
            if (id == 1 && k == 13) chk("s1_busy_hold", busy, 1'b1);
            if (id == 1 && k == 14) chk("s1_busy_lo", busy, 1'b0);
            if (id == 2 && k == 14) chk("s2_sig_lo", sig, 1'b0);
            if (id == 2 && k == 17) chk("s2_busy_hold", busy, 1'b1);
            if (id == 2 && k == 18) chk("s2_busy_lo", busy, 1'b0);
            if (id == 3 && k == 13) chk("s3_cancel", dropped, 1'b1);
            if (id == 4 && k == 10) chk("s4_drop", dropped, 1'b1);
            if (id == 4 && k == 11) chk("s4_drop_end", dropped, 1'b0);
            if (id == 6 && k == 13) chk("s6_rst_sig", sig, 1'b0);
        end
    endtask

    initial begin
        rise  = 1'b0;
        fall  = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        scn(1, 10, -1, -1, -1, -1);
        scn(2, 10, -1, 12, -1, -1);
        scn(3, 10, 13, 12, -1, -1);
        scn(4, 10, -1, 10, -1, -1);
        scn(5, 10, -1, 12, 13, -1);
        scn(6, 10, -1, 12, -1, 13);
        scn(7, 10, -1, 14, -1, -1);   // request in expiry cycle, empty slot
        scn(8, 10, -1, 12, 14, -1);   // duplicate in expiry cycle
        scn(9, 10, 14, 12, -1, -1);   // cancel in expiry cycle

        for (int i = 0; i < 3000; i++) begin
            int   p;
            logic r;
            logic f;
            p = int'($urandom_range(0, 99));
            r = logic'(p < 15 || p >= 95);
            f = logic'((p >= 15 && p < 30) || p >= 95);
            step(r, f, logic'($urandom_range(0, 79) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_generator.md
# edge_generator

Drives a clean output level from single-cycle rise/fall request pulses, guaranteeing each level is held for at least HOLD_COUNT cycles before it can change again. It is the transmit-side counterpart of the input debounce/edge-detect path. It sits between control logic, which issues edge requests, and any output pin or downstream block that needs glitch-free, rate-limited transitions, such as LED drivers, strobes, or reset/enable lines to external parts. One request can be queued while a hold window is active.

## Interface

- HOLD_COUNT, 32: minimum number of cycles each output level is held after a transition; legal range ≥ 2
- RESET_LEVEL, 1'b0: value of `signal` during and after reset

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rise  input  1  single-cycle request to drive `signal` high
- fall  input  1  single-cycle request to drive `signal` low
- signal  output  1  registered output level
- busy  output  1  high while a hold window is active
- dropped  output  1  one-cycle pulse: a request was discarded or overwritten

## Operation

- States: IDLE, HOLD. The hold counter is $clog2(HOLD_COUNT) bits wide and counts 0..HOLD_COUNT-1.
- Pending slot:
  - Fields: `pend_valid` and `pend_level`.
  - It is only written in HOLD.
- Request decode, every cycle:
  - rise&fall both high: conflict. No state change; `dropped`=1.
  - rise only: target=1.
  - fall only: target=0.
  - Neither: no request.
- IDLE:
  - target != signal: toggle `signal`, clear counter, go to HOLD.
  - target == signal: no-op, no `dropped`.
- HOLD, request present:
  - target != signal, no pending: store it in the pending slot.
  - target != signal, pending already valid: overwrite with the same value; `dropped`=1 (duplicate).
  - target == signal, pending valid: clear the pending slot; `dropped`=1 (cancelled).
  - target == signal, no pending: no-op.
- HOLD, counter reaches HOLD_COUNT-1:
  - Pending valid: toggle `signal` to `pend_level`, clear the pending slot, clear the counter, stay in HOLD.
  - Otherwise: go to IDLE.
- A request arriving in the expiry cycle:
  - It is evaluated against the pending slot as it stands before expiry.
  - If no pending is valid, the request is treated as an IDLE request and may toggle immediately in that cycle.
  - Never more than one toggle per cycle.
- `busy` = (state == HOLD).
- `dropped` is registered and deasserts the cycle after any pulse.

## Timing

- Reset (synchronous, highest priority):
  - `signal`=RESET_LEVEL, `busy`=0, `dropped`=0.
  - Pending slot cleared, counter=0, state=IDLE.
  - Any request in the reset cycle is ignored.
- Reset mid-hold aborts the window and discards any pending request, without a `dropped` pulse.
- Request latency: a request sampled at edge N from IDLE changes `signal` after edge N. `busy` rises at the same edge.
- Hold guarantee:
  - If a transition happens at edge T, the next transition happens no earlier than edge T+HOLD_COUNT.
  - So `signal` is stable for at least HOLD_COUNT cycles.
- A pending request is applied exactly at edge T+HOLD_COUNT. Back-to-back windows keep `busy` high continuously.
- With no pending request, `busy` falls after edge T+HOLD_COUNT.
- `dropped` is asserted in the cycle after the offending request edge, for exactly one cycle.

## Test plan

All scenarios use HOLD_COUNT=4 and RESET_LEVEL=0.

- Reset, then a rise at cycle 10 -> `signal`=1 and `busy`=1 from cycle 11; `busy`=0 from cycle 15; `dropped` never asserts.
- Rise at 10, fall at 12 -> `signal`=1 for cycles 11-14, then 0 from cycle 15; `busy` stays high through cycle 18; `busy` low at 19.
- Rise at 10, fall at 12, rise at 13 -> pending cancelled and `dropped`=1 at cycle 14; `signal` stays 1; `busy`=0 at 15.
- Rise and fall together at 10, from IDLE -> `signal` stays 0, `busy` stays 0, `dropped`=1 at cycle 11 only.
- Rise at 10, fall at 12, fall at 13 -> `dropped`=1 at 14; a single transition to 0 at 15.
- Rise at 10, fall at 12, reset at 13 -> at 14: `signal`=0, `busy`=0, `dropped`=0; no transition at 15.
